// File: rtl/sigmoid_stream_checker.sv
// Streams PATTERN x samples to a sigmoid unit and scores its y responses
// against a golden ROM, accumulating the sum of squared errors.
module sigmoid_stream_checker #(
  parameter int PATTERN = 256,
  parameter int TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_start,
  output logic [7:0]  o_x,
  output logic        o_x_valid,
  input  logic [15:0] i_y,
  input  logic        i_y_valid,
  output logic [7:0]  o_gold_addr,
  input  logic [15:0] i_gold_data,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_fail,
  output logic        o_timeout,
  output logic [47:0] o_sse,
  output logic [39:0] o_score,
  output logic [15:0] o_cycles
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] STREAM = 3'd1;
  localparam logic [2:0] DRAIN  = 3'd2;
  localparam logic [2:0] DONE   = 3'd3;
  localparam logic [2:0] FAIL   = 3'd4;
  localparam logic [2:0] TOUT   = 3'd5;

  localparam int         TW     = $clog2(TIMEOUT + 1);
  localparam logic [8:0] PAT    = PATTERN[8:0];
  localparam logic [8:0] PAT_M1 = PAT - 9'd1;
  localparam logic [TW-1:0] TO_M1 = TW'(TIMEOUT - 1);

  logic [2:0]    state_q, state_d;
  logic [8:0]    tx_q, tx_d;
  logic [8:0]    rx_q, rx_d;
  logic [TW-1:0] to_q, to_d;
  logic [15:0]   cyc_q, cyc_d;
  logic [15:0]   y_q, y_d;
  logic          pend_q, pend_d;
  logic [47:0]   sse_q, sse_d;

  logic          busy;
  logic          accept;
  logic [15:0]   diff;
  logic [31:0]   err;

  assign busy   = (state_q == STREAM) || (state_q == DRAIN);
  assign accept = busy && i_y_valid && (rx_q < PAT);
  assign diff   = (y_q >= i_gold_data) ? (y_q - i_gold_data) : (i_gold_data - y_q);
  assign err    = {16'd0, diff} * {16'd0, diff};

  // The golden ROM is addressed by rx_q so its data lines up with y_q
  // on the cycle after acceptance, when the pending error is folded in.
  always_comb begin
    state_d = state_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    to_d    = to_q;
    cyc_d   = cyc_q;
    y_d     = y_q;
    pend_d  = 1'b0;
    sse_d   = sse_q;

    if (pend_q) sse_d = sse_q + {16'd0, err};

    if (!busy) begin
      if (i_start) begin
        state_d = STREAM;
        tx_d    = '0;
        rx_d    = '0;
        to_d    = '0;
        cyc_d   = '0;
        y_d     = '0;
        sse_d   = '0;
      end
    end else begin
      if (state_q == STREAM) begin
        tx_d = tx_q + 9'd1;
        if (tx_q == PAT_M1) state_d = DRAIN;
      end
      if (rx_q < PAT) cyc_d = cyc_q + 16'd1;
      if (accept) begin
        y_d    = i_y;
        rx_d   = rx_q + 9'd1;
        pend_d = 1'b1;
      end
      if ((rx_q == 9'd0) && !i_y_valid) to_d = to_q + 1'b1;

      if (pend_q && (rx_q == PAT))
        state_d = DONE;
      else if ((rx_q != 9'd0) && (rx_q < PAT) && !i_y_valid)
        state_d = FAIL;
      else if ((rx_q == 9'd0) && !i_y_valid && (to_q == TO_M1))
        state_d = TOUT;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      tx_q    <= '0;
      rx_q    <= '0;
      to_q    <= '0;
      cyc_q   <= '0;
      y_q     <= '0;
      pend_q  <= 1'b0;
      sse_q   <= '0;
    end else begin
      state_q <= state_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      to_q    <= to_d;
      cyc_q   <= cyc_d;
      y_q     <= y_d;
      pend_q  <= pend_d;
      sse_q   <= sse_d;
    end
  end

  assign o_x_valid   = (state_q == STREAM);
  assign o_x         = (state_q == STREAM) ? tx_q[7:0] : 8'd0;
  assign o_gold_addr = rx_q[7:0];
  assign o_busy      = busy;
  assign o_done      = (state_q == DONE);
  assign o_fail      = (state_q == FAIL);
  assign o_timeout   = (state_q == TOUT);
  assign o_sse       = sse_q;
  assign o_score     = sse_q[47:8];
  assign o_cycles    = cyc_q;

endmodule

// File: tb/tb_sigmoid_stream_checker.sv
// Self-checking bench: emulates a fixed-latency sigmoid unit and a golden ROM,
// and compares the checker's verdicts against an arithmetic reference model.
module tb_sigmoid_stream_checker;

  logic        clk;
  logic        rst_n;
  logic        i_start;
  logic [7:0]  o_x;
  logic        o_x_valid;
  logic [15:0] i_y;
  logic        i_y_valid;
  logic [7:0]  o_gold_addr;
  logic [15:0] i_gold_data;
  logic        o_busy;
  logic        o_done;
  logic        o_fail;
  logic        o_timeout;
  logic [47:0] o_sse;
  logic [39:0] o_score;
  logic [15:0] o_cycles;

  int tests = 0;
  int fails = 0;

  logic [15:0] gold [256];
  logic [15:0] ys   [256];

  sigmoid_stream_checker #(.PATTERN(256), .TIMEOUT(1024)) dut (
    .clk(clk), .rst_n(rst_n), .i_start(i_start),
    .o_x(o_x), .o_x_valid(o_x_valid),
    .i_y(i_y), .i_y_valid(i_y_valid),
    .o_gold_addr(o_gold_addr), .i_gold_data(i_gold_data),
    .o_busy(o_busy), .o_done(o_done), .o_fail(o_fail), .o_timeout(o_timeout),
    .o_sse(o_sse), .o_score(o_score), .o_cycles(o_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Golden ROM with one cycle of read latency.
  always @(posedge clk) i_gold_data <= gold[o_gold_addr];

  function automatic longint expSse();
    longint s = 0;
    for (int i = 0; i < 256; i++) begin
      longint d = longint'(ys[i]) - longint'(gold[i]);
      s += d * d;
    end
    return s;
  endfunction

  task automatic fillYs(input int mode);
    for (int i = 0; i < 256; i++) begin
      case (mode)
        0:       ys[i] = gold[i];
        1:       ys[i] = gold[i] + 16'd2;
        default: ys[i] = 16'($urandom);
      endcase
    end
  endtask

  // Starts a run and plays a sigmoid unit of latency lat. Returns the cycle
  // (relative to the start edge) at which a sticky flag was first seen, or
  // resetAt when told to stop early. A drop of one valid cycle is inserted
  // where sample dropAt would have arrived.
  task automatic runStream(input int lat, input int dropAt, input int pulseAt,
                           input int resetAt, output int endCycle,
                           output int xCount, output bit xOk);
    int c = 0;
    bit fin = 0;
    xCount = 0;
    xOk = 1'b1;
    endCycle = -1;
    @(negedge clk);
    i_start = 1'b1;
    i_y_valid = 1'b0;
    @(posedge clk);
    while (!fin && c < 3000) begin
      @(negedge clk);
      i_start = (c == pulseAt);
      if (o_done || o_fail || o_timeout || c == resetAt) begin
        endCycle = c;
        fin = 1'b1;
        i_y_valid = 1'b0;
        i_start = 1'b0;
      end else begin
        int idx = c - lat;
        int lim = (dropAt >= 0) ? 257 : 256;
        int sIdx = (dropAt >= 0 && idx > dropAt) ? idx - 1 : idx;
        if (o_x_valid) begin
          if (o_x !== 8'(xCount)) xOk = 1'b0;
          xCount++;
        end else if (o_x !== 8'd0) xOk = 1'b0;
        i_y_valid = (idx >= 0) && (idx < lim) && (idx != dropAt);
        i_y = (i_y_valid && sIdx >= 0 && sIdx < 256) ? ys[sIdx] : 16'($urandom);
        c++;
      end
    end
    i_start = 1'b0;
    i_y_valid = 1'b0;
  endtask

  task automatic checkDoneRun(input string name, input int lat, input int endCycle,
                              input int xCount, input bit xOk);
    longint e = expSse();
    tests++;
    if (o_done !== 1'b1 || o_fail !== 1'b0 || o_timeout !== 1'b0 || o_busy !== 1'b0) begin
      fails++;
      $display("[TB] FAIL %s_flags: done=%b fail=%b tout=%b busy=%b, required 1 0 0 0",
               name, o_done, o_fail, o_timeout, o_busy);
    end
    tests++;
    if (o_sse !== 48'(e) || o_score !== 40'(e >> 8)) begin
      fails++;
      $display("[TB] FAIL %s_sse: sse=%0d score=%0d, required %0d %0d",
               name, o_sse, o_score, e, e >> 8);
    end
    tests++;
    if (o_cycles !== 16'(lat + 256) || endCycle != lat + 257) begin
      fails++;
      $display("[TB] FAIL %s_timing: cycles=%0d doneAt=%0d, required %0d %0d",
               name, o_cycles, endCycle, lat + 256, lat + 257);
    end
    tests++;
    if (xCount != 256 || !xOk) begin
      fails++;
      $display("[TB] FAIL %s_xseq: count=%0d inOrder=%b, required 256 1", name, xCount, xOk);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    i_start = 1'b0;
    i_y_valid = 1'b0;
    i_y = 16'd0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    tests++;
    if (o_busy !== 1'b0 || o_x_valid !== 1'b0 || o_x !== 8'd0 || o_done !== 1'b0 ||
        o_fail !== 1'b0 || o_timeout !== 1'b0 || o_sse !== 48'd0 || o_cycles !== 16'd0 ||
        o_gold_addr !== 8'd0) begin
      fails++;
      $display("[TB] FAIL reset_state: busy=%b xv=%b x=%0d done=%b sse=%0d cyc=%0d, required all 0",
               o_busy, o_x_valid, o_x, o_done, o_sse, o_cycles);
    end
  endtask

  task automatic test_ideal();
    int ec, xc; bit ok;
    fillYs(0);
    runStream(3, -1, -1, -1, ec, xc, ok);
    checkDoneRun("ideal", 3, ec, xc, ok);
  endtask

  task automatic test_offset();
    int ec, xc; bit ok;
    fillYs(1);
    runStream(3, -1, -1, -1, ec, xc, ok);
    tests++;
    if (o_sse !== 48'd1024 || o_score !== 40'd4) begin
      fails++;
      $display("[TB] FAIL offset_sse: sse=%0d score=%0d, required 1024 4", o_sse, o_score);
    end
    checkDoneRun("offset", 3, ec, xc, ok);
  endtask

  task automatic test_random_latency();
    int ec, xc; bit ok;
    int lats [3] = '{0, 1, 17};
    foreach (lats[k]) begin
      fillYs(2);
      runStream(lats[k], -1, -1, -1, ec, xc, ok);
      checkDoneRun($sformatf("rand_lat%0d", lats[k]), lats[k], ec, xc, ok);
    end
  endtask

  task automatic test_ignore_after_done();
    logic [47:0] sseHold;
    sseHold = o_sse;
    repeat (5) begin
      @(negedge clk);
      i_y_valid = 1'b1;
      i_y = 16'($urandom);
    end
    @(negedge clk);
    i_y_valid = 1'b0;
    tests++;
    if (o_sse !== sseHold || o_done !== 1'b1 || o_busy !== 1'b0) begin
      fails++;
      $display("[TB] FAIL ignore_after_done: sse=%0d done=%b busy=%b, required %0d 1 0",
               o_sse, o_done, o_busy, sseHold);
    end
  endtask

  task automatic test_drop();
    int ec, xc; bit ok;
    fillYs(2);
    runStream(3, 100, -1, -1, ec, xc, ok);
    tests++;
    if (o_fail !== 1'b1 || o_done !== 1'b0 || o_timeout !== 1'b0 || o_busy !== 1'b0 || ec != 104) begin
      fails++;
      $display("[TB] FAIL drop_fail: fail=%b done=%b tout=%b busy=%b at=%0d, required 1 0 0 0 104",
               o_fail, o_done, o_timeout, o_busy, ec);
    end
  endtask

  task automatic test_timeout();
    int ec, xc; bit ok;
    fillYs(2);
    runStream(100000, -1, -1, -1, ec, xc, ok);
    tests++;
    if (o_timeout !== 1'b1 || o_done !== 1'b0 || o_fail !== 1'b0 || o_sse !== 48'd0 || ec != 1024) begin
      fails++;
      $display("[TB] FAIL timeout: tout=%b done=%b fail=%b sse=%0d at=%0d, required 1 0 0 0 1024",
               o_timeout, o_done, o_fail, o_sse, ec);
    end
    tests++;
    if (xc != 256 || !ok) begin
      fails++;
      $display("[TB] FAIL timeout_xseq: count=%0d inOrder=%b, required 256 1", xc, ok);
    end
  endtask

  task automatic test_mid_reset();
    int ec, xc; bit ok;
    fillYs(2);
    runStream(3, -1, -1, 50, ec, xc, ok);
    tests++;
    if (o_x !== 8'd50 || o_x_valid !== 1'b1) begin
      fails++;
      $display("[TB] FAIL pre_reset_x: x=%0d xv=%b, required 50 1", o_x, o_x_valid);
    end
    #1 rst_n = 1'b0;
    #1;
    tests++;
    if (o_x_valid !== 1'b0 || o_x !== 8'd0 || o_busy !== 1'b0 || o_gold_addr !== 8'd0 ||
        o_done !== 1'b0 || o_fail !== 1'b0 || o_timeout !== 1'b0 || o_sse !== 48'd0 ||
        o_score !== 40'd0 || o_cycles !== 16'd0) begin
      fails++;
      $display("[TB] FAIL async_reset: xv=%b x=%0d busy=%b addr=%0d sse=%0d cyc=%0d, required all 0",
               o_x_valid, o_x, o_busy, o_gold_addr, o_sse, o_cycles);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    tests++;
    if (o_busy !== 1'b0 || o_x_valid !== 1'b0) begin
      fails++;
      $display("[TB] FAIL idle_after_reset: busy=%b xv=%b, required 0 0", o_busy, o_x_valid);
    end
    fillYs(2);
    runStream(3, -1, -1, -1, ec, xc, ok);
    checkDoneRun("post_reset", 3, ec, xc, ok);
  endtask

  task automatic test_start_during_stream();
    int ec, xc; bit ok;
    fillYs(2);
    runStream(5, -1, 40, -1, ec, xc, ok);
    checkDoneRun("start_ignored", 5, ec, xc, ok);
  endtask

  task automatic test_back_to_back();
    int ec, xc; bit ok;
    fillYs(1);
    runStream(2, -1, -1, -1, ec, xc, ok);
    fillYs(2);
    runStream(4, -1, -1, -1, ec, xc, ok);
    checkDoneRun("back_to_back", 4, ec, xc, ok);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) gold[i] = 16'($urandom_range(0, 65000));
    test_reset();
    test_ideal();
    test_ignore_after_done();
    test_offset();
    test_random_latency();
    test_drop();
    test_timeout();
    test_mid_reset();
    test_start_during_stream();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
